bias_add_relu_pack: RTL and testbench
=====================================

Name: bias_add_relu_pack

Overview:
- Downstream consumer of the packed bias vector produced by the layer bias loader.
- Latches the bias vector once the loader signals done.
- Accepts one signed accumulator result per neuron over a valid/ready stream.
- Per neuron: adds the bias, arithmetic-shifts, applies ReLU, saturates to W bits, and packs into a layer output vector for the next layer.

Parameters:
- OUT_SIZE, 8, number of neurons; bias entries and accumulator results per pass.
- W, 8, bias and output element width; two's complement.
- ACC_W, 24, accumulator input width; signed.
- BIAS_SHIFT, 4, left shift applied to the sign-extended bias to align with accumulator scale.
- OUT_SHIFT, 6, arithmetic right shift applied to the sum before ReLU/saturation.
- IDX_W, 4, index counter width; must satisfy 2^IDX_W > OUT_SIZE.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bias_in  in  OUT_SIZE*W  packed biases; element i at [i*W +: W].
- bias_done  in  1  level from bias loader; bias_in stable while high.
- start  in  1  single-cycle pulse; begins a pass.
- acc_valid  in  1  acc_data valid.
- acc_data  in  ACC_W  signed accumulator result for the current neuron index.
- acc_ready  out  1  block accepts acc_data this cycle.
- data_out  out  OUT_SIZE*W  packed results; element i at [i*W +: W].
- done  out  1  high while a completed pass result is held.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bias_reg=0, bias_ok=0, idx=0.
  - data_out=0, acc_ready=0, done=0.
  - Reset mid-pass aborts the pass; a partial data_out is discarded (zeroed).
- bias_ok:
  - Set, and bias_reg<=bias_in, on the first cycle bias_done=1 while bias_ok=0.
  - Afterwards bias_reg is frozen; later bias_in changes are ignored until reset.
- States:
  - IDLE: on start, clear data_out and idx=0. Go to RUN if bias_ok (or bias_done is high this same cycle), else WAIT_BIAS.
  - WAIT_BIAS: acc_ready=0. Go to RUN the cycle after bias_ok becomes 1.
  - RUN: acc_ready=1 (registered; high from the first RUN cycle). On each handshake (acc_valid&&acc_ready):
    - sum = acc_data + (signext(bias_reg[idx]) <<< BIAS_SHIFT), computed at ACC_W+1 bits, no overflow wrap.
    - shifted = sum >>> OUT_SHIFT.
    - res = (shifted<0) ? 0 : (shifted > 2^(W-1)-1 ? 2^(W-1)-1 : shifted).
    - data_out[idx] <= res on the handshake edge; idx++.
    - On the handshake with idx==OUT_SIZE-1: go to DONE, drop acc_ready the next cycle.
  - DONE: done=1, acc_ready=0, data_out held. start returns to the IDLE start action: clear data_out, idx=0, go to RUN (bias_ok already 1); done falls the next cycle.
- Stall/flow:
  - acc_valid=0 in RUN: no change.
  - acc_valid high outside RUN: ignored, not consumed.
- Throughput and latency:
  - One element per cycle.
  - done rises exactly 1 cycle after the last handshake edge (registered).
- start in RUN or WAIT_BIAS: ignored.
- Simultaneous start and bias_done in IDLE: bias latched and state goes to RUN directly.
- All outputs are registered.

Optional Feature:
- Macro BIAS_ADD_ROUND_EN.
- Defined: before the right shift, add 2^(OUT_SHIFT-1) to sum (round-half-up). Only valid when OUT_SHIFT>=1.
- Undefined: plain truncating arithmetic shift (floor).
- Saturation and ReLU are identical in both builds.

Test Plan:
- Reset then bias_done=1 with all biases 0x01. Start, then 8 back-to-back acc_data=64 → each sum 64+16=80, >>>6 = 1 → data_out all 0x01; done high 1 cycle after the 8th handshake.
- Bias[0]=0x80 (-128); acc_data[0]=0 → sum -2048 → ReLU 0. acc_data[1]=0x7FFFFF with bias 0 → saturates to 0x7F.
- Start before bias_done: stays in WAIT_BIAS, acc_ready=0 for 5 cycles. bias_done rises → RUN the next cycle. Results use the latched bias; a later bias_in change has no effect.
- acc_valid toggled 1,0,0,1,... in RUN: idx advances only on handshakes; done after exactly 8 accepts.
- Reset pulsed after 3 accepts: all outputs 0 immediately (asynchronous). A new pass after re-latching the bias completes normally.
- With BIAS_ADD_ROUND_EN, bias=0 and acc_data=32: result 1 (0 without the macro). acc_data=31: result 0 in both builds.

Source files
------------

// File: rtl/bias_add_relu_pack.sv
// bias_add_relu_pack
//   Latches the packed bias vector from the layer bias loader, then for each
//   neuron adds the scaled bias to a streamed accumulator result, applies an
//   arithmetic right shift, ReLU and saturation, and packs the result into a
//   layer output vector.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bias_in    packed biases, element i at [i*W +: W]
//   bias_done  loader done level; bias_in stable while high
//   start      single-cycle pulse, begins a pass
//   acc_valid  acc_data valid
//   acc_data   signed accumulator result for the current neuron
//   acc_ready  block accepts acc_data this cycle
//   data_out   packed results, element i at [i*W +: W]
//   done       high while a completed pass result is held
//
// Optional build macro: BIAS_ADD_ROUND_EN
//   defined   -> round-half-up before the right shift (needs OUT_SHIFT >= 1)
//   undefined -> truncating (floor) arithmetic shift
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_BIAS | pass requested, bias vector not yet latched
// RUN       | accepting one accumulator result per neuron
// DONE      | pass complete, data_out held
module bias_add_relu_pack #(
  parameter int OUT_SIZE   = 8,
  parameter int W          = 8,
  parameter int ACC_W      = 24,
  parameter int BIAS_SHIFT = 4,
  parameter int OUT_SHIFT  = 6,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OUT_SIZE*W-1:0] bias_in,
  input  logic                  bias_done,
  input  logic                  start,
  input  logic                  acc_valid,
  input  logic [ACC_W-1:0]      acc_data,
  output logic                  acc_ready,
  output logic [OUT_SIZE*W-1:0] data_out,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, WAIT_BIAS, RUN, DONE} state_t;

  state_t                state;
  logic [OUT_SIZE*W-1:0] bias_reg;
  logic                  bias_ok;
  logic [IDX_W-1:0]      idx;

  logic [W-1:0]          bias_el;
  logic signed [ACC_W:0] bias_ext;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;
  logic [W-1:0]          res;
  logic                  hs;
  logic                  last;

  assign bias_el = bias_reg[idx*W +: W];
  assign hs      = acc_valid && acc_ready;
  assign last    = (idx == IDX_W'(OUT_SIZE - 1));

  // Sum is one bit wider than the accumulator so bias addition never wraps.
  always_comb begin
    bias_ext = {{(ACC_W + 1 - W){bias_el[W-1]}}, bias_el};
    bias_ext = bias_ext <<< BIAS_SHIFT;
    sum      = {acc_data[ACC_W-1], acc_data} + bias_ext;
`ifdef BIAS_ADD_ROUND_EN
    sum      = sum + (ACC_W+1)'(2 ** (OUT_SHIFT - 1));
`endif
    shifted  = sum >>> OUT_SHIFT;
    res      = '0;
    if (shifted < 0)
      res = '0;
    else if (shifted > (ACC_W+1)'(2 ** (W - 1) - 1))
      res = {1'b0, {(W-1){1'b1}}};
    else
      res = shifted[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bias_reg  <= '0;
      bias_ok   <= 1'b0;
      idx       <= '0;
      data_out  <= '0;
      acc_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (!bias_ok && bias_done) begin
        bias_ok  <= 1'b1;
        bias_reg <= bias_in;
      end

      case (state)
        IDLE: begin
          if (start) begin
            data_out <= '0;
            idx      <= '0;
            if (bias_ok || bias_done) begin
              state     <= RUN;
              acc_ready <= 1'b1;
            end else begin
              state <= WAIT_BIAS;
            end
          end
        end
        WAIT_BIAS: begin
          acc_ready <= 1'b0;
          if (bias_ok) begin
            state     <= RUN;
            acc_ready <= 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            data_out[idx*W +: W] <= res;
            idx                  <= idx + 1'b1;
            if (last) begin
              state     <= DONE;
              acc_ready <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            data_out  <= '0;
            idx       <= '0;
            state     <= RUN;
            acc_ready <= 1'b1;
            done      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_add_relu_pack.sv
module tb_bias_add_relu_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] bias_in;
  logic        bias_done;
  logic        start;
  logic        acc_valid;
  logic [23:0] acc_data;
  logic        acc_ready;
  logic [63:0] data_out;
  logic        done;

  int tests = 0;
  int fails = 0;

  bias_add_relu_pack dut (
    .clk(clk), .rst_n(rst_n), .bias_in(bias_in), .bias_done(bias_done),
    .start(start), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_ready(acc_ready), .data_out(data_out), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic [7:0] a [8]);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = a[i];
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_reset();
    acc_valid = 1'b0; start = 1'b0; bias_done = 1'b0; acc_data = '0;
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // One handshake: holds acc_valid until acc_ready is seen, bounded.
  task automatic send(input logic [23:0] d);
    int n;
    n = 0;
    acc_valid = 1'b1; acc_data = d;
    while (!acc_ready && n < 20) begin cyc(); n++; end
    if (!acc_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: acc_ready=%b required 1", acc_ready);
    end
    cyc();
    acc_valid = 1'b0;
  endtask

  task automatic test_reset();
    bias_in = '0;
    do_reset();
    tests++;
    if (data_out !== 64'h0 || acc_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: data_out=%h ready=%b done=%b required 0/0/0", data_out, acc_ready, done);
    end
  endtask

  task automatic test_basic();
    bias_in = pk('{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01});
    bias_done = 1'b1;
    cyc();
    pulse_start();
    tests++;
    if (acc_ready !== 1'b1) begin
      fails++; $display("FAIL basic_ready: acc_ready=%b required 1", acc_ready);
    end
    for (int i = 0; i < 7; i++) send(24'd64);
    tests++;
    if (done !== 1'b0 || acc_ready !== 1'b1) begin
      fails++; $display("FAIL basic_pre_done: done=%b ready=%b required 0/1", done, acc_ready);
    end
    send(24'd64);
    tests++;
    if (done !== 1'b1 || acc_ready !== 1'b0) begin
      fails++; $display("FAIL basic_done: done=%b ready=%b required 1/0", done, acc_ready);
    end
    tests++;
    if (data_out !== 64'h0101010101010101) begin
      fails++; $display("FAIL basic_data: data_out=%h required 0101010101010101", data_out);
    end
    acc_valid = 1'b1; acc_data = 24'h7FFFFF;
    repeat (2) cyc();
    acc_valid = 1'b0;
    tests++;
    if (data_out !== 64'h0101010101010101 || done !== 1'b1) begin
      fails++; $display("FAIL done_hold: data_out=%h done=%b required 0101010101010101/1", data_out, done);
    end
  endtask

  task automatic test_relu_sat();
    logic [63:0] exp_v;
    do_reset();
    bias_in = pk('{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF});
    bias_done = 1'b1;
    cyc();
    pulse_start();
    send(24'd0);        // -2048 -> 0
    send(24'h7FFFFF);   // 131071 -> 0x7F
    send(24'hFFFFFF);   // -1 -> 0
    send(24'd4032);     // 63
    send(24'd8128);     // 127
    send(24'd8192);     // 128 -> 0x7F
    send(24'h800000);   // most negative -> 0
    send(24'd144);      // 144-16=128 -> 2
    exp_v = pk('{8'h00, 8'h7F, 8'h00, 8'h3F, 8'h7F, 8'h7F, 8'h00, 8'h02});
    tests++;
    if (data_out !== exp_v || done !== 1'b1) begin
      fails++; $display("FAIL relu_sat: data_out=%h done=%b required %h/1", data_out, done, exp_v);
    end
  endtask

  task automatic test_wait_bias();
    logic [63:0] exp_v;
    do_reset();
    bias_in = pk('{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02});
    pulse_start();
    acc_valid = 1'b1; acc_data = 24'h7FFFFF;  // must not be consumed
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (acc_ready !== 1'b0) begin
        fails++; $display("FAIL wait_ready cycle %0d: acc_ready=%b required 0", i, acc_ready);
      end
      cyc();
    end
    bias_done = 1'b1;
    acc_valid = 1'b0;
    cyc();
    tests++;
    if (acc_ready !== 1'b0) begin
      fails++; $display("FAIL wait_latch_cycle: acc_ready=%b required 0", acc_ready);
    end
    cyc();
    tests++;
    if (acc_ready !== 1'b1) begin
      fails++; $display("FAIL wait_to_run: acc_ready=%b required 1", acc_ready);
    end
    bias_in = pk('{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10});
    for (int i = 0; i < 8; i++) send(24'(32 + 64 * i));
    exp_v = pk('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    tests++;
    if (data_out !== exp_v || done !== 1'b1) begin
      fails++; $display("FAIL wait_data: data_out=%h done=%b required %h/1", data_out, done, exp_v);
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_v;
    pulse_start();
    tests++;
    if (done !== 1'b0 || data_out !== 64'h0 || acc_ready !== 1'b1) begin
      fails++; $display("FAIL restart: done=%b data_out=%h ready=%b required 0/0/1", done, data_out, acc_ready);
    end
    for (int i = 0; i < 8; i++) begin
      send(24'(64 * i - 32));
      if (i == 3) begin
        pulse_start();  // ignored in RUN
        tests++;
        if (data_out !== pk('{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0})) begin
          fails++; $display("FAIL start_in_run: data_out=%h required 0000000003020100", data_out);
        end
      end else begin
        repeat (2) cyc();
      end
      if (i == 6) begin
        tests++;
        if (done !== 1'b0) begin
          fails++; $display("FAIL stall_early_done: done=%b required 0", done);
        end
      end
    end
    exp_v = pk('{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
    tests++;
    if (data_out !== exp_v || done !== 1'b1) begin
      fails++; $display("FAIL stall_data: data_out=%h done=%b required %h/1", data_out, done, exp_v);
    end
  endtask

  task automatic test_reset_midpass();
    pulse_start();
    for (int i = 0; i < 3; i++) send(24'd288);
    tests++;
    if (data_out !== pk('{8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0})) begin
      fails++; $display("FAIL partial: data_out=%h required 0000000000050505", data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (data_out !== 64'h0 || acc_ready !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL async_reset: data_out=%h ready=%b done=%b required 0/0/0", data_out, acc_ready, done);
    end
    cyc();
    rst_n = 1'b1;
    cyc();   // bias_done still high, bias_in = 0x10 re-latched here
    pulse_start();
    for (int i = 0; i < 8; i++) send(24'd0);
    tests++;
    if (data_out !== 64'h0404040404040404 || done !== 1'b1) begin
      fails++; $display("FAIL relatch: data_out=%h done=%b required 0404040404040404/1", data_out, done);
    end
  endtask

  task automatic test_round_and_simul();
    logic [7:0] r0;
`ifdef BIAS_ADD_ROUND_EN
    r0 = 8'd1;
`else
    r0 = 8'd0;
`endif
    do_reset();
    bias_in = '0;
    bias_done = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests++;
    if (acc_ready !== 1'b1) begin
      fails++; $display("FAIL simul_start_bias: acc_ready=%b required 1", acc_ready);
    end
    send(24'd32);
    send(24'd31);
    for (int i = 0; i < 6; i++) send(24'd64);
    tests++;
    if (data_out !== {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, r0} || done !== 1'b1) begin
      fails++; $display("FAIL round: data_out=%h done=%b required %h/1", data_out, done,
                        {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, r0});
    end
  endtask

  initial begin
    rst_n = 1'b0; bias_in = '0; bias_done = 1'b0; start = 1'b0;
    acc_valid = 1'b0; acc_data = '0;
    test_reset();
    test_basic();
    test_relu_sat();
    test_wait_bias();
    test_stall();
    test_reset_midpass();
    test_round_and_simul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
